// File: rtl/div_defs_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and the
// bit-counter width helper.
package div_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DIV_SIZE = 8;

  // The counter must hold SIZE itself, hence SIZE+1 distinct values.
  function automatic int cnt_width(input int size);
    return $clog2(size + 1);
  endfunction

  localparam int CNT_W = cnt_width(DIV_SIZE);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, and keep the difference only when it does not borrow.
module div_step #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] rem,
  input  logic            quot_msb,
  input  logic [SIZE-1:0] divisor,
  output logic [SIZE-1:0] rem_next,
  output logic            q_bit
);

  logic [SIZE:0]   shifted;
  logic [SIZE+1:0] trial;

  // rem < divisor on entry, so shifted < 2*divisor fits SIZE+1 bits; the
  // extra top bit of trial is only the borrow.
  assign shifted  = {rem, quot_msb};
  assign trial    = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit    = ~trial[SIZE+1];
  assign rem_next = q_bit ? SIZE'(trial) : SIZE'(shifted);

endmodule

// File: rtl/div8.sv
// Sequential restoring divider: one quotient bit per clock, quotient and
// remainder presented with a one-cycle done strobe.
module div8
  import div_defs::*;
#(
  parameter int SIZE = DIV_SIZE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic [SIZE-1:0] quot,
  output logic [SIZE-1:0] rem,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero
);

  localparam int CW = cnt_width(SIZE);

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [SIZE-1:0] divisor_r;
  logic [SIZE-1:0] rem_next;
  logic            q_bit;

  div_step #(.SIZE(SIZE)) u_step (
    .rem      (rem),
    .quot_msb (quot[SIZE-1]),
    .divisor  (divisor_r),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = (divisor == '0) ? S_DONE : S_CALC;
      S_CALC: if (cnt == CW'(1)) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // quot doubles as the dividend shift register: its MSB feeds each step and
  // the new quotient bit enters at the LSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quot        <= '0;
      rem         <= '0;
      cnt         <= '0;
      divisor_r   <= '0;
      div_by_zero <= 1'b0;
    end else if (state == S_IDLE && start) begin
      if (divisor != '0) begin
        quot        <= dividend;
        rem         <= '0;
        cnt         <= CW'(SIZE);
        divisor_r   <= divisor;
        div_by_zero <= 1'b0;
      end else begin
        quot        <= '1;
        rem         <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == S_CALC) begin
      quot <= {quot[SIZE-2:0], q_bit};
      rem  <= rem_next;
      cnt  <= cnt - CW'(1);
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_div8.sv
// Scoreboard bench for div8: the driver queues expected results, a monitor
// pops and checks them on every done strobe.
module tb_div8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [7:0] divisor = 8'd0;
  logic [7:0] quot, rem;
  logic       busy, done, div_by_zero;

  div8 #(.SIZE(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quot        (quot),
    .rem         (rem),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int z;
    int lat;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: checks each done against the oldest queued expectation.
  initial begin
    int   busy_run;
    exp_t e;
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_run = 0;
      end else begin
        if (busy) busy_run++;
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk($sformatf("quot %0d/%0d", e.a, e.b), int'(quot), e.q);
            chk($sformatf("rem %0d/%0d", e.a, e.b), int'(rem), e.r);
            chk($sformatf("dbz %0d/%0d", e.a, e.b), int'(div_by_zero), e.z);
            chk($sformatf("latency %0d/%0d", e.a, e.b), cyc - e.acc + 1, e.lat);
            chk($sformatf("busy_len %0d/%0d", e.a, e.b), busy_run, e.lat);
            if (e.b != 0) begin
              chk($sformatf("invariant %0d/%0d", e.a, e.b),
                  int'(quot) * e.b + int'(rem), e.a);
              chk($sformatf("rem_lt_div %0d/%0d", e.a, e.b),
                  int'(rem < 8'(e.b)), 1);
            end
          end
        end
        if (!busy) busy_run = 0;
      end
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_pending", sb.size(), 0);
  endtask

  // Presents operands on an idle negedge; the next rising edge accepts them.
  task automatic issue(input int a, input int b, input int q, input int r,
                       input int z, input bit hold);
    exp_t e;
    wait_idle();
    dividend = a[7:0];
    divisor  = b[7:0];
    start    = 1'b1;
    e.a = a; e.b = b; e.q = q; e.r = r; e.z = z;
    e.lat = (b == 0) ? 1 : 9;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  int dvs[10] = '{1, 2, 3, 7, 16, 100, 127, 128, 200, 255};

  initial begin
    #2;
    chk("rst_quot", int'(quot), 0);
    chk("rst_rem", int'(rem), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    issue(200, 7, 28, 4, 0, 1'b0);
    issue(255, 1, 255, 0, 0, 1'b0);
    issue(5, 9, 0, 5, 0, 1'b0);
    issue(0, 3, 0, 0, 0, 1'b0);
    issue(77, 0, 255, 77, 1, 1'b0);
    issue(10, 3, 3, 1, 0, 1'b0);
    drain();

    // A start pulse during CALC must be dropped.
    issue(100, 10, 10, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    dividend = 8'd9;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (15) @(negedge clk);
    chk("hold_quot", int'(quot), 10);
    chk("hold_rem", int'(rem), 0);

    // Reset mid-CALC abandons the operation.
    wait_idle();
    dividend = 8'd250;
    divisor  = 8'd4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_quot", int'(quot), 0);
    chk("midrst_rem", int'(rem), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    issue(250, 4, 62, 2, 0, 1'b0);

    // Round-trip products back through the divider.
    issue(247, 19, 13, 0, 0, 1'b0);
    issue(255, 17, 15, 0, 0, 1'b0);
    issue(255, 85, 3, 0, 0, 1'b0);
    drain();

    // Sweep with start held high between requests.
    for (int i = 0; i < 16; i++) begin
      int a;
      a = (i == 15) ? 255 : i * 17;
      for (int j = 0; j < 10; j++)
        issue(a, dvs[j], a / dvs[j], a % dvs[j], 0, 1'b1);
      issue(a, 0, 255, a, 1, 1'b1);
    end
    start = 1'b0;
    drain();
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
